// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one memory fetch per instruction,
// hands the fetched word downstream, then advances, redirects or halts.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            level; leaves IDLE to begin fetching
//   imem_ack         memory presents imem_rdata this cycle (honoured only in FETCH)
//   imem_rdata       instruction word from memory
//   stall            downstream not ready; hold the current instruction
//   halt             current instruction is a halt (sampled in ISSUE)
//   branch_taken     redirect to branch_target (sampled in ISSUE)
//   branch_target    redirect address
//   pc               current program counter
//   imem_req         fetch request, held until acknowledged or timed out
//   imem_addr        fetch address, always equal to pc
//   instr            latched instruction word
//   instr_valid      instr is valid for downstream (ISSUE only)
//   busy             high in FETCH or ISSUE
//   err_timeout      sticky: a fetch went unacknowledged for TIMEOUT_CYCLES
module instr_fetch_ctrl #(
    parameter logic [7:0]  MAX_PC         = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [27:0] branch_target,
    output logic [27:0] pc,
    output logic        imem_req,
    output logic [27:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int unsigned PC_W   = 28;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_seq;
    logic [DATA_W-1:0]  instr_d;
    logic               req_d;
    logic               valid_d;
    logic               busy_d;
    logic               err_d;

    // pc is a flop, so the fetch address is registered and tracks it exactly
    assign imem_addr = pc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Sequential successor: low byte hitting MAX_PC clears the whole pc
    assign pc_seq = (pc[7:0] == MAX_PC) ? '0 : pc + PC_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc;
        instr_d = instr;
        req_d   = imem_req;
        valid_d = instr_valid;
        busy_d  = busy;
        err_d   = err_timeout;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            FETCH: begin
                // An ack in the final wait cycle still wins over the timeout
                if (imem_ack) begin
                    state_d = ISSUE;
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = HALTED;
                    cnt_d   = cnt_inc;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end

            ISSUE: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (halt) begin
                        state_d = HALTED;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        pc_d    = branch_taken ? branch_target : pc_seq;
                    end
                end
            end

            HALTED: begin
                // Terminal until reset
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc          <= '0;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc          <= pc_d;
            instr       <= instr_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
            busy        <= busy_d;
            err_timeout <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: the bench plays instruction
// memory and downstream, and predicts fetch addresses and issued words
// from the program-counter rules.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [27:0] branch_target;
    logic [27:0] pc;
    logic        imem_req;
    logic [27:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    logic [27:0] exp_pc;
    logic [31:0] exp_instr;

    instr_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference rule for the next fetch address after an issued instruction
    function automatic logic [27:0] model_next(input logic [27:0] cur, input logic br,
                                               input logic [27:0] tgt);
        int unsigned low;
        low = int'(cur % 256);
        if (br) return tgt;
        if (low == 255) return 28'd0;
        return cur + 28'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_target = '0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_pc = '0;
        exp_instr = '0;
    endtask

    // Leave IDLE; the first request must appear on the next edge
    task automatic start_fetch();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_fetch: req=%b addr=%h busy=%b, required req=1 addr=%h busy=1",
                     imem_req, imem_addr, busy, exp_pc);
        end
    endtask

    // Serve the outstanding request after 'delay' wait cycles
    task automatic fetch_one(input int delay, input logic [31:0] data);
        for (int i = 0; i < delay; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
                failures++;
                $display("FAIL fetch_wait: req=%b valid=%b addr=%h, required req=1 valid=0 addr=%h",
                         imem_req, instr_valid, imem_addr, exp_pc);
            end
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        exp_instr = data;
        checks++;
        if (instr_valid !== 1'b1 || instr !== data || imem_req !== 1'b0 ||
            pc !== exp_pc || busy !== 1'b1 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack: valid=%b instr=%h req=%b pc=%h busy=%b err=%b, required 1 %h 0 %h 1 0",
                     instr_valid, instr, imem_req, pc, busy, err_timeout, data, exp_pc);
        end
    endtask

    // Hold ISSUE for nstall cycles, then release with the given halt/branch
    task automatic issue_one(input int nstall, input logic hlt, input logic br,
                             input logic [27:0] tgt, input logic stray_ack);
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1;
            imem_ack = stray_ack;
            imem_rdata = $urandom;
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== exp_instr || pc !== exp_pc || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL issue_stall: valid=%b instr=%h pc=%h req=%b, required 1 %h %h 0",
                         instr_valid, instr, pc, imem_req, exp_instr, exp_pc);
            end
        end
        stall = 1'b0;
        imem_ack = 1'b0;
        halt = hlt;
        branch_taken = br;
        branch_target = tgt;
        tick();
        halt = 1'b0;
        branch_taken = 1'b0;
        branch_target = 28'($urandom);
        checks++;
        if (hlt) begin
            if (busy !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== exp_pc) begin
                failures++;
                $display("FAIL issue_halt: busy=%b req=%b valid=%b pc=%h, required 0 0 0 %h",
                         busy, imem_req, instr_valid, pc, exp_pc);
            end
        end else begin
            exp_pc = model_next(exp_pc, br, tgt);
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL issue_next: req=%b addr=%h valid=%b busy=%b, required 1 %h 0 1",
                         imem_req, imem_addr, instr_valid, busy, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, imem_req, imem_addr, instr, instr_valid, busy, err_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_values: pc=%h req=%b addr=%h instr=%h valid=%b busy=%b err=%b, required all zero",
                     pc, imem_req, imem_addr, instr, instr_valid, busy, err_timeout);
        end
        imem_ack = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 || instr !== '0) begin
            failures++;
            $display("FAIL idle_hold: req=%b busy=%b valid=%b instr=%h, required 0 0 0 0",
                     imem_req, busy, instr_valid, instr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        start_fetch();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (imem_addr !== 28'(i)) begin
                failures++;
                $display("FAIL seq_addr: addr=%h, required %h", imem_addr, 28'(i));
            end
            fetch_one(2, $urandom);
            issue_one(0, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [27:0] bases [3];
        bases[0] = 28'h00000FE;
        bases[1] = 28'h00001FE;
        bases[2] = 28'hABCDEFE;
        for (int b = 0; b < 3; b++) begin
            fetch_one(1, $urandom);
            issue_one(0, 1'b0, 1'b1, bases[b], 1'b0);
            fetch_one(0, $urandom);
            issue_one(0, 1'b0, 1'b0, '0, 1'b0);
            fetch_one(0, $urandom);
            issue_one(0, 1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (imem_addr !== 28'h0000000 || pc !== 28'h0000000) begin
                failures++;
                $display("FAIL wrap_%0d: addr=%h pc=%h, required 0000000", b, imem_addr, pc);
            end
        end
    endtask

    task automatic test_branch_halt();
        do_reset();
        start_fetch();
        for (int i = 0; i < 5; i++) begin
            fetch_one(0, $urandom);
            issue_one(0, 1'b0, 1'b0, '0, 1'b0);
        end
        fetch_one(1, $urandom);
        issue_one(0, 1'b0, 1'b1, 28'h0000040, 1'b0);
        checks++;
        if (imem_addr !== 28'h0000040) begin
            failures++;
            $display("FAIL branch_addr: addr=%h, required 0000040", imem_addr);
        end

        do_reset();
        start_fetch();
        for (int i = 0; i < 5; i++) begin
            fetch_one(0, $urandom);
            issue_one(0, 1'b0, 1'b0, '0, 1'b0);
        end
        fetch_one(0, $urandom);
        issue_one(0, 1'b1, 1'b1, 28'h0000040, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 28'd5 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL halted_hold: req=%b busy=%b pc=%h valid=%b, required 0 0 0000005 0",
                         imem_req, busy, pc, instr_valid);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        start_fetch();
        fetch_one(0, 32'hCAFE0001);
        issue_one(3, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (imem_addr !== 28'd1) begin
            failures++;
            $display("FAIL stall_next: addr=%h, required 0000001", imem_addr);
        end
        // Long waits back to back: the wait counter must restart each fetch
        fetch_one(14, $urandom);
        issue_one(0, 1'b0, 1'b0, '0, 1'b0);
        fetch_one(14, $urandom);
        issue_one(1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        start_fetch();
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL timeout_len: req high %0d cycles, required 16", n);
        end
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_flags: err=%b busy=%b req=%b, required 1 0 0", err_timeout, busy, imem_req);
        end
        start = 1'b1;
        imem_ack = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b busy=%b req=%b valid=%b, required 1 0 0 0",
                     err_timeout, busy, imem_req, instr_valid);
        end

        // Ack arriving in the 16th wait cycle beats the timeout
        do_reset();
        start_fetch();
        fetch_one(15, 32'h1234ABCD);
        issue_one(0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_ack_wins: err=%b, required 0", err_timeout);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        start_fetch();
        for (int i = 0; i < 3; i++) begin
            fetch_one(0, $urandom);
            issue_one(0, 1'b0, 1'b0, '0, 1'b0);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, imem_req, imem_addr, instr, instr_valid, busy, err_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_async: pc=%h req=%b addr=%h instr=%h valid=%b busy=%b err=%b, required all zero",
                     pc, imem_req, imem_addr, instr, instr_valid, busy, err_timeout);
        end
        tick();
        rst_n = 1'b1;
        exp_pc = '0;
        start_fetch();
        fetch_one(1, $urandom);
        issue_one(0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        start_fetch();
        for (int i = 0; i < 40; i++) begin
            fetch_one(int'($urandom_range(0, 6)), $urandom);
            issue_one(int'($urandom_range(0, 3)), 1'b0, ($urandom % 4) == 0,
                      28'($urandom), 1'($urandom));
        end
        fetch_one(0, $urandom);
        issue_one(0, 1'b1, 1'($urandom), 28'($urandom), 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch_halt();
        test_stall();
        test_timeout();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter MAX_PC, default 8'hFF: value of pc[7:0] at which the sequential PC wraps to 0.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: fetch-wait cycles without imem_ack before a timeout error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level; begins fetching from IDLE.
REQ-006 imem_ack  input  1  instruction memory has imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 stall  input  1  downstream not ready; holds the current instruction.
REQ-009 halt  input  1  current instruction is a halt (sampled with instr_valid).
REQ-010 branch_taken  input  1  redirect PC (sampled with instr_valid).
REQ-011 branch_target  input  28  redirect address.
REQ-012 pc  output  28  current program counter.
REQ-013 imem_req  output  1  fetch request, held until ack.
REQ-014 imem_addr  output  28  fetch address; equals pc whenever imem_req=1.
REQ-015 instr  output  32  latched instruction.
REQ-016 instr_valid  output  1  instr is valid for downstream.
REQ-017 busy  output  1  high in FETCH or ISSUE.
REQ-018 err_timeout  output  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, HALTED; all outputs registered.
REQ-020 IDLE: start=1 -> FETCH next cycle; otherwise stay.
REQ-021 FETCH: imem_req=1, imem_addr=pc; imem_ack=1 -> latch imem_rdata into instr, go ISSUE, imem_req deasserts the same edge.
REQ-022 Ack-to-instr_valid latency SHALL be exactly 1 cycle; imem_ack outside FETCH SHALL be ignored.
REQ-023 ISSUE: instr_valid=1; stall=1 -> stay, instr and pc unchanged.
REQ-024 ISSUE, stall=0, halt=1 -> HALTED; pc unchanged; halt has priority over branch_taken.
REQ-025 ISSUE, stall=0, halt=0, branch_taken=1 -> pc <= branch_target, go FETCH.
REQ-026 ISSUE, stall=0, halt=0, branch_taken=0 -> pc <= 0 if pc[7:0]==MAX_PC, else pc+1 (28-bit, no carry-out); go FETCH.
REQ-027 instr_valid SHALL be high only in ISSUE; one cycle per instruction when stall=0.
REQ-028 Timeout counter clears on FETCH entry, increments each FETCH cycle with imem_ack=0; reaching TIMEOUT_CYCLES -> err_timeout<=1, imem_req<=0, go HALTED.
REQ-029 imem_ack in the cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal ISSUE, no error).
REQ-030 HALTED SHALL be terminal until reset; start ignored; imem_req=0, instr_valid=0, busy=0.
REQ-031 busy SHALL be 1 in FETCH and ISSUE, 0 in IDLE and HALTED.
REQ-032 start deasserting after leaving IDLE SHALL have no effect.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, pc=0, instr=0, imem_req=0, instr_valid=0, busy=0, err_timeout=0, counter=0, regardless of state (including mid-handshake).
REQ-034 After rst_n rises, the first FETCH SHALL use imem_addr=0.

Verification
REQ-035 Reset, start=1, ack 2 cycles after each req, no stall -> addresses 0,1,2,..., instr_valid one cycle per fetch, instr matches rdata.
REQ-036 Run until pc=0x0FF, branch_taken=0 -> next imem_addr=0x0000000; pc=0x1FF behaves identically (wraps to 0).
REQ-037 At pc=5, branch_taken=1, target=0x0000040 -> next imem_addr=0x40; with halt=1 also asserted -> HALTED, pc=5, no further req.
REQ-038 stall=1 for 3 ISSUE cycles -> instr_valid held 4 cycles, instr and pc stable, then pc+1 fetched.
REQ-039 imem_ack never asserted -> imem_req high exactly 16 cycles, then err_timeout=1, busy=0, start ignored; ack in cycle 16 -> no error.
REQ-040 rst_n pulsed low mid-FETCH -> imem_req drops asynchronously, all outputs at reset values, restart fetches address 0.
